// File: rtl/matrix_loader.sv
// matrix_loader: write-side loader for the systolic-array operand banks.
// Accepts one MxM matrix streamed row-major over valid/ready and scatters each
// element into the N1 A banks (bank = row mod N1) or the N2 B banks
// (bank = col mod N2), matching the layout the read address generator uses.
// Optional feature: define MATRIX_LOADER_LAST_CHECK_EN to check in_last framing
// and raise a sticky err; otherwise in_last is ignored and err is tied low.
module matrix_loader #(
  parameter int N1  = 4,
  parameter int N2  = 4,
  parameter int M   = 8,
  parameter int D_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          sel_B,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [D_W-1:0]                in_data,
  input  logic                          in_last,
  output logic [N1-1:0]                 wr_en_A,
  output logic [$clog2((M*M)/N1)-1:0]   wr_addr_A,
  output logic [D_W-1:0]                wr_data_A,
  output logic [N2-1:0]                 wr_en_B,
  output logic [$clog2((M*M)/N2)-1:0]   wr_addr_B,
  output logic [D_W-1:0]                wr_data_B,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int RW    = $clog2(M);
  localparam int AW_A  = $clog2((M*M)/N1);
  localparam int AW_B  = $clog2((M*M)/N2);
  localparam int N1_LG = $clog2(N1);
  localparam int N2_LG = $clog2(N2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row, col;
  logic            sel;
  logic            accept;
  logic            last_elem;
  logic            start_acc;
  logic [N1-1:0]   bank_a_oh;
  logic [N2-1:0]   bank_b_oh;
  logic [AW_A-1:0] addr_a;
  logic [AW_B-1:0] addr_b;

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid & in_ready;
  assign start_acc = (state_q == IDLE) & start;
  assign last_elem = (row == RW'(M-1)) && (col == RW'(M-1));

  // Power-of-2 geometry: mod is a low-bit mask, divide/multiply are shifts.
  assign bank_a_oh = N1'(1) << (row & RW'(N1-1));
  assign bank_b_oh = N2'(1) << (col & RW'(N2-1));
  assign addr_a    = AW_A'(((int'(row) >> N1_LG) << RW) + int'(col));
  assign addr_b    = AW_B'(((int'(col) >> N2_LG) << RW) + int'(row));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && last_elem) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Element counters, selection latch and registered bank write port.
  // done is registered from DONE, so it pulses the cycle after the final write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      sel       <= 1'b0;
      wr_en_A   <= '0;
      wr_addr_A <= '0;
      wr_data_A <= '0;
      wr_en_B   <= '0;
      wr_addr_B <= '0;
      wr_data_B <= '0;
      done      <= 1'b0;
    end else begin
      wr_en_A <= '0;
      wr_en_B <= '0;
      done    <= (state_q == DONE);
      if (start_acc) begin
        sel <= sel_B;
        row <= '0;
        col <= '0;
      end
      if (accept) begin
        if (sel) begin
          wr_en_B   <= bank_b_oh;
          wr_addr_B <= addr_b;
          wr_data_B <= in_data;
        end else begin
          wr_en_A   <= bank_a_oh;
          wr_addr_A <= addr_a;
          wr_data_A <= in_data;
        end
        col <= col + RW'(1);
        if (col == RW'(M-1)) row <= row + RW'(1);
      end
    end
  end

`ifdef MATRIX_LOADER_LAST_CHECK_EN
  logic err_q;

  // Sticky framing error: in_last must be high exactly on the final element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err_q <= 1'b0;
    else if (start_acc)                       err_q <= 1'b0;
    else if (accept && (in_last != last_elem)) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Directed testbench for matrix_loader (M=8, N1=N2=4, D_W=8).
// Streams data = 8*r+c, logs every bank write, and compares each write against
// the expected bank/address/data/latency computed from the element index.
module tb_matrix_loader;

  localparam int M   = 8;
  localparam int N1  = 4;
  localparam int N2  = 4;
  localparam int D_W = 8;
  localparam int AW  = 4;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic           clk, rst, start, sel_B, in_valid, in_ready, in_last;
  logic [D_W-1:0] in_data;
  logic [N1-1:0]  wr_en_A;
  logic [AW-1:0]  wr_addr_A;
  logic [D_W-1:0] wr_data_A;
  logic [N2-1:0]  wr_en_B;
  logic [AW-1:0]  wr_addr_B;
  logic [D_W-1:0] wr_data_B;
  logic           busy, done, err;

  matrix_loader #(.N1(N1), .N2(N2), .M(M), .D_W(D_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_B(sel_B),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .wr_en_A(wr_en_A), .wr_addr_A(wr_addr_A), .wr_data_A(wr_data_A),
    .wr_en_B(wr_en_B), .wr_addr_B(wr_addr_B), .wr_data_B(wr_data_B),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Write log filled by the monitor; indices wrap at 1024.
  logic [N1-1:0]  w_en_a   [1024];
  logic [N2-1:0]  w_en_b   [1024];
  logic [AW-1:0]  w_addr_a [1024];
  logic [AW-1:0]  w_addr_b [1024];
  logic [D_W-1:0] w_data_a [1024];
  logic [D_W-1:0] w_data_b [1024];
  int             w_cyc    [1024];
  int             acc_cyc  [M*M];
  int cyc = 0, wcnt = 0, dcnt = 0, d_cyc = 0;
  int wbase, dbase;

  // Monitor: sample outputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (wr_en_A != '0 || wr_en_B != '0) begin
      w_en_a[wcnt & 1023]   = wr_en_A;
      w_en_b[wcnt & 1023]   = wr_en_B;
      w_addr_a[wcnt & 1023] = wr_addr_A;
      w_addr_b[wcnt & 1023] = wr_addr_B;
      w_data_a[wcnt & 1023] = wr_data_A;
      w_data_b[wcnt & 1023] = wr_data_B;
      w_cyc[wcnt & 1023]    = cyc;
      wcnt++;
    end
    if (done) begin
      dcnt++;
      d_cyc = cyc;
    end
  end

  // One load; inputs are driven on falling edges. bad >= 0 raises in_last on
  // that beat, rst_at >= 0 asserts reset before that beat, restart_at pulses
  // start mid-load, hold keeps in_valid high for a few cycles after the load.
  task automatic do_load(input logic selb, input int gap, input int bad,
                         input int rst_at, input int restart_at, input bit hold);
    int k = 0;
    int guard = 0;
    bit chk_err;
    wbase = wcnt;
    dbase = dcnt;
    @(negedge clk);
    start = 1'b1;
    sel_B = selb;
    @(negedge clk);
    start = 1'b0;
    sel_B = 1'b0;
    check("in_ready after start", in_ready, 1);
    check("err cleared by start", err, 0);
    while (k < M*M && guard < 4000) begin
      if (k == rst_at) begin
        in_valid = 1'b0;
        check("write in flight before rst", (wr_en_A != '0), 1);
        #2 rst = 1'b1;
        #1;
        check("rst wr_en_A", wr_en_A, 0);
        check("rst wr_addr_A", wr_addr_A, 0);
        check("rst wr_data_A", wr_data_A, 0);
        check("rst busy", busy, 0);
        check("rst in_ready", in_ready, 0);
        check("partial writes", wcnt - wbase, rst_at);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      in_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
      in_data  = 8'(k);
      in_last  = (k == M*M-1) || (k == bad);
      start    = (k == restart_at);
      chk_err  = 1'b0;
      if (in_valid && in_ready) begin
        acc_cyc[k] = cyc;
        chk_err    = (k == bad);
        k++;
      end
      @(negedge clk);
      guard++;
      if (chk_err) check("err after bad beat", err, LAST_EN);
    end
    if (k < M*M) check("load timeout beats", k, M*M);
    in_valid = hold;
    in_last  = 1'b0;
    start    = 1'b0;
    check("in_ready in DONE", in_ready, 0);
    check("busy in DONE", busy, 1);
    repeat (hold ? 5 : 2) begin
      @(negedge clk);
      check("in_ready after load", in_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  // Compare the logged writes of the last load against the expected layout.
  task automatic verify_load(input logic selb, input string tag);
    int n = wcnt - wbase;
    check({tag, " write count"}, n, M*M);
    check({tag, " done count"}, dcnt - dbase, 1);
    for (int i = 0; i < M*M && i < n; i++) begin
      int r = i / M;
      int c = i % M;
      int j = (wbase + i) & 1023;
      int ea = selb ? 0 : (1 << (r % N1));
      int eb = selb ? (1 << (c % N2)) : 0;
      int ad = selb ? (M * (c / N2) + r) : (M * (r / N1) + c);
      check($sformatf("%s w%0d en_A", tag, i), w_en_a[j], ea);
      check($sformatf("%s w%0d en_B", tag, i), w_en_b[j], eb);
      check($sformatf("%s w%0d addr", tag, i), selb ? w_addr_b[j] : w_addr_a[j], ad);
      check($sformatf("%s w%0d data", tag, i), selb ? w_data_b[j] : w_data_a[j], i);
      check($sformatf("%s w%0d latency", tag, i), w_cyc[j], acc_cyc[i] + 1);
    end
    if (n > 0) check({tag, " done cycle"}, d_cyc, w_cyc[(wbase + n - 1) & 1023] + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sel_B = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset wr_en_A", wr_en_A, 0);
    check("reset wr_en_B", wr_en_B, 0);
    check("reset wr_addr_A", wr_addr_A, 0);
    check("reset wr_addr_B", wr_addr_B, 0);
    check("reset wr_data_A", wr_data_A, 0);
    check("reset wr_data_B", wr_data_B, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 0);
    check("reset err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", in_ready, 0);

    // Load A, continuous stream, hand-computed spot checks.
    do_load(1'b0, 0, -1, -1, -1, 1'b0);
    verify_load(1'b0, "loadA");
    check("A(0,0) en", w_en_a[wbase & 1023], 4'b0001);
    check("A(0,0) addr", w_addr_a[wbase & 1023], 0);
    check("A(5,3) en", w_en_a[(wbase + 43) & 1023], 4'b0010);
    check("A(5,3) addr", w_addr_a[(wbase + 43) & 1023], 11);
    check("A(5,3) data", w_data_a[(wbase + 43) & 1023], 43);
    check("A(7,7) en", w_en_a[(wbase + 63) & 1023], 4'b1000);
    check("A(7,7) addr", w_addr_a[(wbase + 63) & 1023], 15);
    check("A(7,7) data", w_data_a[(wbase + 63) & 1023], 63);

    // Load B with a start pulse mid-load and in_valid held after DONE.
    do_load(1'b1, 0, -1, -1, 30, 1'b1);
    verify_load(1'b1, "loadB");
    check("B(3,6) en", w_en_b[(wbase + 30) & 1023], 4'b0100);
    check("B(3,6) addr", w_addr_b[(wbase + 30) & 1023], 11);
    check("B(3,6) data", w_data_b[(wbase + 30) & 1023], 30);
    check("B(7,1) en", w_en_b[(wbase + 57) & 1023], 4'b0010);
    check("B(7,1) addr", w_addr_b[(wbase + 57) & 1023], 7);
    check("B(7,1) data", w_data_b[(wbase + 57) & 1023], 57);

    // Load A with ~50% in_valid gaps.
    do_load(1'b0, 50, -1, -1, -1, 1'b0);
    verify_load(1'b0, "gapA");

    // Reset at beat 20, then a fresh load must restart at (0,0).
    do_load(1'b0, 0, -1, 20, -1, 1'b0);
    do_load(1'b0, 0, -1, -1, -1, 1'b0);
    verify_load(1'b0, "postrstA");
    check("postrst first en", w_en_a[wbase & 1023], 4'b0001);
    check("postrst first addr", w_addr_a[wbase & 1023], 0);

    // Framing: in_last on beat 10; err only when the check is built in.
    do_load(1'b0, 0, 10, -1, -1, 1'b0);
    verify_load(1'b0, "badlastA");
    check("err sticky after done", err, LAST_EN);
    do_load(1'b1, 0, -1, -1, -1, 1'b0);
    verify_load(1'b1, "goodlastB");
    check("err after clean load", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
